// File: rtl/bpsk_packet_modem.sv
// BPSK link core: parallel-load packet serializer and sine modulator on the
// transmit side, coherent correlating demodulator with preamble framing on
// the receive side. One carrier cycle spans one bit period.
module bpsk_packet_modem #(
    parameter int PACKET_SIZE     = 192,
    parameter int DATA_WIDTH      = 12,
    parameter int SAMPLES_PER_BIT = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [PACKET_SIZE-1:0] packet,
    input  logic                   tx_start,
    input  logic                   tx_enable,
    output logic [DATA_WIDTH-1:0]  tx_sample,
    output logic                   tx_busy,
    output logic                   tx_done,
    input  logic [DATA_WIDTH-1:0]  rx_sample,
    output logic [7:0]             rx_byte,
    output logic                   rx_valid,
    output logic                   rx_locked
);

    localparam int K_W   = $clog2(SAMPLES_PER_BIT);
    localparam int BIT_W = $clog2(PACKET_SIZE);
    localparam int BYTES = PACKET_SIZE / 8 - 1;
    localparam int BC_W  = $clog2(BYTES + 1);
    localparam int PW    = 2 * DATA_WIDTH + 2;
    localparam int ACC_W = PW + K_W;

    localparam logic [DATA_WIDTH-1:0] MID       = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [K_W-1:0]        K_LAST    = K_W'(SAMPLES_PER_BIT - 1);
    localparam logic [K_W-1:0]        K_ONE     = K_W'(1);
    localparam logic [K_W-1:0]        K_TWO     = K_W'(2);
    localparam logic [BIT_W-1:0]      BIT_LAST  = BIT_W'(PACKET_SIZE - 1);
    localparam logic [BC_W-1:0]       BYTE_LAST = BC_W'(BYTES - 1);
    localparam logic signed [DATA_WIDTH:0] QUARTER =
        {3'b000, 1'b1, {(DATA_WIDTH-3){1'b0}}};
    localparam logic signed [ACC_W-1:0] STRONG =
        {{(ACC_W-2*DATA_WIDTH+1){1'b0}}, 1'b1, {(2*DATA_WIDTH-2){1'b0}}};

    // One carrier cycle of signed sine samples, amplitude MID-1, rounded.
    logic signed [DATA_WIDTH:0] sine_tab [SAMPLES_PER_BIT];
    for (genvar g = 0; g < SAMPLES_PER_BIT; g++) begin : g_sine
        localparam real AMP = (2.0 ** (DATA_WIDTH - 1) - 1.0) *
                              $sin(2.0 * 3.14159265358979 * g / SAMPLES_PER_BIT);
        localparam int  VAL = (AMP >= 0.0) ? $rtoi(AMP + 0.5) : -$rtoi(0.5 - AMP);
        assign sine_tab[g] = VAL[DATA_WIDTH:0];
    end

    // Offset-binary sample for one bit: MID plus or minus the sine value.
    function automatic logic [DATA_WIDTH-1:0] modulate(input logic b,
                                                       input logic signed [DATA_WIDTH:0] s);
        logic signed [DATA_WIDTH+1:0] mid_ext;
        logic signed [DATA_WIDTH+1:0] s_ext;
        logic signed [DATA_WIDTH+1:0] v;
        mid_ext = {2'b00, MID};
        s_ext   = {s[DATA_WIDTH], s};
        v       = b ? (mid_ext + s_ext) : (mid_ext - s_ext);
        return v[DATA_WIDTH-1:0];
    endfunction

    // Carrier-present detector on the centred receive sample.
    function automatic logic over_quarter(input logic signed [DATA_WIDTH:0] c);
        logic signed [DATA_WIDTH:0] mag;
        mag = c[DATA_WIDTH] ? -c : c;
        return mag > QUARTER;
    endfunction

    // A bit decision is trusted only when the correlation is large enough.
    function automatic logic is_strong(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] mag;
        mag = a[ACC_W-1] ? -a : a;
        return mag >= STRONG;
    endfunction

    logic [PACKET_SIZE-1:0] tx_shift;
    logic [K_W-1:0]         tx_phase;
    logic [BIT_W-1:0]       tx_bits;

    // Serializer and modulator: one phase step per enabled busy cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            tx_sample <= MID;
            tx_phase  <= '0;
            tx_bits   <= '0;
        end else begin
            tx_done <= 1'b0;
            if (!tx_busy) begin
                tx_sample <= MID;
                if (tx_start) begin
                    tx_shift <= packet;
                    tx_busy  <= 1'b1;
                    tx_phase <= '0;
                    tx_bits  <= '0;
                end
            end else if (!tx_enable) begin
                tx_sample <= MID;
            end else begin
                tx_sample <= modulate(tx_shift[PACKET_SIZE-1], sine_tab[tx_phase]);
                if (tx_phase == K_LAST) begin
                    tx_phase <= '0;
                    tx_shift <= tx_shift << 1;
                    if (tx_bits == BIT_LAST) begin
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                    end else begin
                        tx_bits <= tx_bits + 1'b1;
                    end
                end else begin
                    tx_phase <= tx_phase + 1'b1;
                end
            end
        end
    end

    typedef enum logic [1:0] {RX_IDLE, RX_HUNT, RX_LOCKED} rx_state_t;

    rx_state_t                  rx_state;
    logic [K_W-1:0]             rx_phase;
    logic signed [ACC_W-1:0]    acc;
    logic [7:0]                 rx_shift;
    logic [2:0]                 rx_bitcnt;
    logic [BC_W-1:0]            rx_bytecnt;
    logic signed [DATA_WIDTH:0] rx_centered;
    logic [K_W-1:0]             rx_idx;
    logic signed [PW-1:0]       rx_cen_ext;
    logic signed [PW-1:0]       rx_sin_ext;
    logic signed [PW-1:0]       rx_product;
    logic signed [ACC_W-1:0]    acc_next;
    logic [7:0]                 shift_next;
    logic                       bit_one;

    // The triggering sample is taken as phase 1, so IDLE correlates with S(1).
    assign rx_centered = $signed({1'b0, rx_sample}) - $signed({1'b0, MID});
    assign rx_idx      = (rx_state == RX_IDLE) ? K_ONE : rx_phase;
    assign rx_cen_ext  = {{(PW-DATA_WIDTH-1){rx_centered[DATA_WIDTH]}}, rx_centered};
    assign rx_sin_ext  = {{(PW-DATA_WIDTH-1){sine_tab[rx_idx][DATA_WIDTH]}}, sine_tab[rx_idx]};
    assign rx_product  = rx_cen_ext * rx_sin_ext;
    assign acc_next    = acc + {{(ACC_W-PW){rx_product[PW-1]}}, rx_product};
    assign bit_one     = !acc_next[ACC_W-1] && (acc_next != '0);
    assign shift_next  = {rx_shift[6:0], bit_one};

    // Correlating receiver: rx_phase is the carrier phase of the current sample.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_state   <= RX_IDLE;
            rx_phase   <= '0;
            acc        <= '0;
            rx_shift   <= '0;
            rx_bitcnt  <= '0;
            rx_bytecnt <= '0;
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            rx_locked  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (rx_state == RX_IDLE) begin
                if (over_quarter(rx_centered)) begin
                    rx_phase <= K_TWO;
                    acc      <= {{(ACC_W-PW){rx_product[PW-1]}}, rx_product};
                    rx_shift <= '0;
                    rx_state <= RX_HUNT;
                end
            end else if (rx_phase != K_LAST) begin
                acc      <= acc_next;
                rx_phase <= rx_phase + 1'b1;
            end else begin
                acc      <= '0;
                rx_phase <= '0;
                if (!is_strong(acc_next)) begin
                    rx_state  <= RX_IDLE;
                    rx_locked <= 1'b0;
                end else if (rx_state == RX_HUNT) begin
                    rx_shift <= shift_next;
                    if (shift_next == 8'hFF) begin
                        rx_state   <= RX_LOCKED;
                        rx_locked  <= 1'b1;
                        rx_bitcnt  <= '0;
                        rx_bytecnt <= '0;
                    end
                end else begin
                    rx_shift  <= shift_next;
                    rx_bitcnt <= rx_bitcnt + 1'b1;
                    if (rx_bitcnt == 3'd7) begin
                        rx_byte  <= shift_next;
                        rx_valid <= 1'b1;
                        if (rx_bytecnt == BYTE_LAST) begin
                            rx_state  <= RX_IDLE;
                            rx_locked <= 1'b0;
                        end else begin
                            rx_bytecnt <= rx_bytecnt + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bpsk_packet_modem.sv
// Loopback bench for bpsk_packet_modem: transmit waveform checked sample by
// sample against a real-valued sine reference, received bytes checked
// against the payload bytes of the packet that was sent.
module tb_bpsk_packet_modem;

    localparam int PS    = 192;
    localparam int DW    = 12;
    localparam int SPB   = 16;
    localparam int MID   = 2048;
    localparam int TOTAL = PS * SPB;
    localparam logic [PS-1:0] MSG = 192'hff5468697320697320612074657374206d65737361676521;

    logic          clock;
    logic          reset_n;
    logic [PS-1:0] packet;
    logic          tx_start;
    logic          tx_enable;
    logic [DW-1:0] tx_sample;
    logic          tx_busy;
    logic          tx_done;
    logic [DW-1:0] rx_sample;
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_locked;

    int checks   = 0;
    int failures = 0;
    logic [7:0] rx_q [$];

    assign rx_sample = tx_sample;

    bpsk_packet_modem #(
        .PACKET_SIZE(PS), .DATA_WIDTH(DW), .SAMPLES_PER_BIT(SPB)
    ) dut (
        .clock(clock), .reset_n(reset_n), .packet(packet),
        .tx_start(tx_start), .tx_enable(tx_enable), .tx_sample(tx_sample),
        .tx_busy(tx_busy), .tx_done(tx_done), .rx_sample(rx_sample),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_locked(rx_locked)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) if (rx_valid) rx_q.push_back(rx_byte);

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Spec sine: round((MID-1) * sin(2*pi*k/SPB)).
    function automatic int sine_ref(input int k);
        real a;
        a = (MID - 1.0) * $sin(2.0 * 3.14159265358979 * k / SPB);
        return (a >= 0.0) ? $rtoi(a + 0.5) : -$rtoi(0.5 - a);
    endfunction

    // Expected sample number n of a packet's waveform (bits MSB first).
    function automatic int wave_ref(input logic [PS-1:0] pkt, input int n);
        logic b;
        b = pkt[PS - 1 - n / SPB];
        return b ? MID + sine_ref(n % SPB) : MID - sine_ref(n % SPB);
    endfunction

    function automatic logic [PS-1:0] rand_pkt;
        logic [PS-1:0] p;
        for (int i = 0; i < PS / 32; i++) p[32*i +: 32] = $urandom;
        p[PS-1 -: 8] = 8'hFF;
        return p;
    endfunction

    // Sends pkt; optionally gaps tx_enable and/or re-strobes tx_start with alt.
    task automatic run_packet(input logic [PS-1:0] pkt, input int gap_at, input int gap_len,
                              input int restart_at, input logic [PS-1:0] alt,
                              output int busy_cycles);
        int n;
        int t;
        rx_q.delete();
        tx_enable = 1'b1;
        packet    = pkt;
        tx_start  = 1'b1;
        tick;
        tx_start = 1'b0;
        check("busy_after_start", tx_busy, 1);
        check("first_edge_mid", tx_sample, MID);
        n = 0;
        t = 0;
        while (n < TOTAL && t < TOTAL + gap_len + 16) begin
            if (t == restart_at) begin
                packet   = alt;
                tx_start = 1'b1;
            end else begin
                tx_start = 1'b0;
            end
            tx_enable = !(t >= gap_at && t < gap_at + gap_len);
            tick;
            t++;
            if (!tx_enable) begin
                check("gap_mid", tx_sample, MID);
                check("gap_busy", tx_busy, 1);
            end else begin
                check("tx_wave", tx_sample, wave_ref(pkt, n));
                check("tx_done", tx_done, (n == TOTAL - 1));
                check("tx_busy", tx_busy, (n != TOTAL - 1));
                if (n == 0)  check("bit0_k0", tx_sample, 2048);
                if (n == 4)  check("bit0_k4", tx_sample, 4095);
                if (n == 8)  check("bit0_k8", tx_sample, 2048);
                if (n == 12) check("bit0_k12", tx_sample, 1);
                n++;
            end
        end
        tx_start  = 1'b0;
        tx_enable = 1'b1;
        check("tx_complete", n, TOTAL);
        busy_cycles = t;
        tick;
        check("idle_mid", tx_sample, MID);
        check("done_pulse_end", tx_done, 0);
        repeat (4) tick;
    endtask

    task automatic check_bytes(input logic [PS-1:0] pkt, input int count);
        check("rx_count", rx_q.size(), count);
        for (int i = 0; i < count && i < rx_q.size(); i++)
            check("rx_byte", rx_q[i], pkt[PS - 9 - 8 * i -: 8]);
        check("rx_unlocked_end", rx_locked, 0);
    endtask

    initial begin
        logic [PS-1:0] p;
        logic [PS-1:0] p2;
        int cyc;

        // Reset with tx_start held high.
        reset_n   = 1'b0;
        tx_start  = 1'b1;
        tx_enable = 1'b1;
        packet    = MSG;
        repeat (3) tick;
        check("rst_sample", tx_sample, MID);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_locked", rx_locked, 0);
        check("rst_byte", rx_byte, 0);
        reset_n  = 1'b1;
        tx_start = 1'b0;
        repeat (5) tick;
        check("post_rst_busy", tx_busy, 0);
        check("post_rst_sample", tx_sample, MID);

        // Waveform on a random packet whose bit 8 is a zero.
        p = rand_pkt();
        p[PS-9] = 1'b0;
        run_packet(p, -1, 0, -1, p, cyc);
        check("wave_pkt_bit8_k4", wave_ref(p, 8 * SPB + 4), 1);
        check("busy_cycles", cyc, TOTAL);
        check_bytes(p, PS / 8 - 1);

        // Loopback decode of the text message.
        run_packet(MSG, -1, 0, -1, MSG, cyc);
        check_bytes(MSG, PS / 8 - 1);
        check("msg_first", (rx_q.size() > 0) ? rx_q[0] : 8'h00, 8'h54);
        check("msg_last", (rx_q.size() > 22) ? rx_q[22] : 8'h00, 8'h21);

        // More random payloads.
        for (int r = 0; r < 2; r++) begin
            p = rand_pkt();
            run_packet(p, -1, 0, -1, p, cyc);
            check_bytes(p, PS / 8 - 1);
        end

        // Enable gap of 40 cycles at bit 43 (byte 5), phase 8.
        run_packet(MSG, 43 * SPB + 8, 40, -1, MSG, cyc);
        check("gap_busy_cycles", cyc, TOTAL + 40);
        check_bytes(MSG, 4);

        // tx_start while busy with a different packet is ignored.
        p  = rand_pkt();
        p2 = rand_pkt();
        p2[PS-10] = ~p[PS-10];
        run_packet(p, -1, 0, 1000, p2, cyc);
        check("restart_busy_cycles", cyc, TOTAL);
        check_bytes(p, PS / 8 - 1);

        // Reset during byte 5.
        rx_q.delete();
        packet   = MSG;
        tx_start = 1'b1;
        tick;
        tx_start = 1'b0;
        repeat (44 * SPB) tick;
        check("pre_rst_locked", rx_locked, 1);
        check("pre_rst_count", rx_q.size(), 4);
        reset_n = 1'b0;
        tick;
        check("mid_rst_sample", tx_sample, MID);
        check("mid_rst_locked", rx_locked, 0);
        check("mid_rst_busy", tx_busy, 0);
        check("mid_rst_valid", rx_valid, 0);
        reset_n = 1'b1;
        repeat (TOTAL) tick;
        check("post_rst_count", rx_q.size(), 4);
        check("post_rst_idle", tx_busy, 0);
        check("post_rst_mid", tx_sample, MID);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
